// File: rtl/dmem_line_ctrl.sv
// dmem_line_ctrl: line-granular (256-bit) data memory behind the L1 data cache.
// One request at a time over an enable/ack handshake; a countdown counter
// models a fixed access latency, then the access is performed and ack pulses.
// Optional macro DMEM_RANGE_CHECK_EN: flags addresses above DEPTH lines as
// out of range (write suppressed, read returns zero, sticky err_o).
module dmem_line_ctrl #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic         ack_o,
  output logic [255:0] data_o,
  output logic         busy_o,
  output logic         err_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic               wr_q;
  logic [255:0]       data_q;
  logic [255:0]       mem_q [DEPTH];

  logic               accept;
  logic               enter_ack;
  logic [IDX_W-1:0]   acc_idx;
  logic               acc_wr;
  logic [255:0]       acc_data;
  logic               acc_oor;
  logic               req_oor;

  assign accept    = (state_q == S_IDLE) && enable_i;
  assign enter_ack = (state_d == S_ACK);
  assign busy_o    = (state_q != S_IDLE);

`ifdef DMEM_RANGE_CHECK_EN
  logic oor_q;
  logic err_q;
  logic unused_addr;
  assign req_oor     = |addr_i[31:5+IDX_W];
  assign err_o       = err_q;
  assign unused_addr = ^addr_i[4:0];
`else
  logic unused_addr;
  logic oor_q;
  // Upper address bits alias onto the DEPTH lines; nothing is out of range.
  assign req_oor     = 1'b0;
  assign oor_q       = 1'b0;
  assign err_o       = 1'b0;
  assign unused_addr = ^{addr_i[31:5+IDX_W], addr_i[4:0]};
`endif

  // State register; reset returns to IDLE and drops any pending request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode: IDLE -> WAIT -> ACK -> IDLE (IDLE -> ACK when LATENCY=1).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (enable_i) state_d = (LATENCY == 1) ? S_ACK : S_WAIT;
      S_WAIT: if (cnt_q == CNT_ONE) state_d = S_ACK;
      S_ACK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Latency countdown: loaded on accept, decremented while waiting.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                 cnt_q <= '0;
    else if (accept)            cnt_q <= CNT_INIT;
    else if (state_q == S_WAIT) cnt_q <= cnt_q - CNT_ONE;
  end

  // Request capture; inputs are ignored after the accepting edge.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      idx_q  <= addr_i[5+IDX_W-1:5];
      wr_q   <= write_i;
      data_q <= data_i;
    end
  end

`ifdef DMEM_RANGE_CHECK_EN
  // Out-of-range flag travels with the request; err_o is sticky until reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      oor_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (accept)              oor_q <= req_oor;
      if (enter_ack && acc_oor) err_q <= 1'b1;
    end
  end
`endif

  // Access operands: with LATENCY=1 the access edge is the accepting edge,
  // so the live inputs are used instead of the (not yet loaded) copies.
  always_comb begin
    acc_idx  = idx_q;
    acc_wr   = wr_q;
    acc_data = data_q;
    acc_oor  = oor_q;
    if (state_q == S_IDLE) begin
      acc_idx  = addr_i[5+IDX_W-1:5];
      acc_wr   = write_i;
      acc_data = data_i;
      acc_oor  = req_oor;
    end
  end

  // Line array write on the edge entering ACK; never touched during reset.
  always_ff @(posedge clk_i) begin
    if (rst_i && enter_ack && acc_wr && !acc_oor) mem_q[acc_idx] <= acc_data;
  end

  // Read data and ack pulse, both launched on the edge entering ACK.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_o <= '0;
      ack_o  <= 1'b0;
    end else begin
      ack_o <= enter_ack;
      if (enter_ack && !acc_wr) data_o <= acc_oor ? '0 : mem_q[acc_idx];
    end
  end

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Testbench for dmem_line_ctrl: directed cases followed by randomized
// read/write traffic, checked against a line-array reference model.
module tb_dmem_line_ctrl;

  localparam int LAT = 10;
  localparam int DEP = 512;
`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         enable_i;
  logic         write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         ack_o;
  logic [255:0] data_o;
  logic         busy_o;
  logic         err_o;

  int checks = 0;
  int errors = 0;

  logic [255:0] model [int];
  logic [255:0] last_rd;
  logic         err_exp;

  dmem_line_ctrl #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .ack_o    (ack_o),
    .data_o   (data_o),
    .busy_o   (busy_o),
    .err_o    (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32) % DEP);
  endfunction

  function automatic bit out_of_range(input logic [31:0] a);
    return RC && ((a / 32) >= DEP);
  endfunction

  function automatic logic [255:0] rnd_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  // Issue one request and follow it to its ack. exp_lat counts edges from
  // driving the request to the edge after which ack_o is seen high.
  task automatic req(input logic wr, input logic [31:0] addr, input logic [255:0] d,
                     input int exp_lat, input int drop_after, input bit keep_en,
                     input string tag);
    int n;
    bit oor;
    int idx;
    logic [255:0] exp_d;
    oor = out_of_range(addr);
    idx = line_of(addr);
    exp_d = last_rd;
    if (!wr) exp_d = oor ? 256'h0 : model[idx];
    enable_i = 1'b1;
    write_i  = wr;
    addr_i   = addr;
    data_i   = d;
    n = 0;
    do begin
      tick();
      n++;
      if (n == drop_after) enable_i = 1'b0;
      if (!ack_o && n > exp_lat - LAT) chk({tag, "_busy"}, {255'h0, busy_o}, 256'h1);
    end while (!ack_o && n < exp_lat + 5);
    chk({tag, "_ack"}, {255'h0, ack_o}, 256'h1);
    chk({tag, "_lat"}, 256'(n), 256'(exp_lat));
    chk({tag, "_busyack"}, {255'h0, busy_o}, 256'h1);
    chk({tag, "_data"}, data_o, exp_d);
    if (wr && !oor) model[idx] = d;
    last_rd = exp_d;
    if (oor) err_exp = 1'b1;
    chk({tag, "_err"}, {255'h0, err_o}, {255'h0, err_exp});
    if (!keep_en) begin
      enable_i = 1'b0;
      tick();
      chk({tag, "_ackpulse"}, {255'h0, ack_o}, 256'h0);
      chk({tag, "_idle"}, {255'h0, busy_o}, 256'h0);
    end
  endtask

  initial begin
    logic [255:0] w_dead;
    logic [255:0] w_1234;
    logic [255:0] w_aaaa;
    int pool [8];
    bit prev_keep;
    w_dead = {8{32'hDEADBEEF}};
    w_1234 = {8{32'h12345678}};
    w_aaaa = {8{32'hAAAA5555}};
    last_rd = 256'h0;
    err_exp = 1'b0;
    rst_i = 1'b0;
    enable_i = 1'b0;
    write_i = 1'b0;
    addr_i = 32'h0;
    data_i = 256'h0;
    tick();
    tick();
    chk("rst_ack", {255'h0, ack_o}, 256'h0);
    chk("rst_busy", {255'h0, busy_o}, 256'h0);
    chk("rst_err", {255'h0, err_o}, 256'h0);
    chk("rst_data", data_o, 256'h0);
    rst_i = 1'b1;
    tick();

    // 1: write, enable held until ack
    req(1'b1, 32'h0000_0400, w_dead, LAT, 0, 1'b0, "t1w");
    // 2: read back, then data_o must hold after enable drops
    req(1'b0, 32'h0000_0400, 256'h0, LAT, 0, 1'b0, "t2r");
    repeat (20) tick();
    chk("t2_hold", data_o, w_dead);
    // 3: write-back then refill back-to-back, then read the written line
    req(1'b1, 32'h0000_0800, w_1234, LAT, 0, 1'b1, "t3w");
    req(1'b0, 32'h0000_0400, 256'h0, LAT + 1, 0, 1'b0, "t3r");
    req(1'b0, 32'h0000_0800, 256'h0, LAT, 0, 1'b0, "t3r2");
    // 4: byte offset bits ignored
    req(1'b0, 32'h0000_041C, 256'h0, LAT, 0, 1'b0, "t4r");
    // 6: upper address bits (range error or aliasing onto line 0)
    req(1'b1, 32'h0000_0000, w_1234, LAT, 0, 1'b0, "t6w0");
    req(1'b1, 32'h0001_0000, w_aaaa, LAT, 0, 1'b0, "t6w");
    req(1'b0, 32'h0000_0000, 256'h0, LAT, 0, 1'b0, "t6r0");
    req(1'b0, 32'h0001_0000, 256'h0, LAT, 0, 1'b0, "t6r");
    chk("t6_sticky", {255'h0, err_o}, {255'h0, err_exp});
    // 5: reset in the middle of a write discards it
    req(1'b1, 32'h0000_0C00, w_aaaa, LAT, 0, 1'b0, "t5w");
    enable_i = 1'b1;
    write_i = 1'b1;
    addr_i = 32'h0000_0C00;
    data_i = 256'h0;
    repeat (5) tick();
    rst_i = 1'b0;
    #1;
    chk("t5_rst_ack", {255'h0, ack_o}, 256'h0);
    chk("t5_rst_busy", {255'h0, busy_o}, 256'h0);
    chk("t5_rst_data", data_o, 256'h0);
    chk("t5_rst_err", {255'h0, err_o}, 256'h0);
    enable_i = 1'b0;
    tick();
    rst_i = 1'b1;
    last_rd = 256'h0;
    err_exp = 1'b0;
    repeat (12) tick();
    chk("t5_noack", {255'h0, ack_o}, 256'h0);
    req(1'b0, 32'h0000_0C00, 256'h0, LAT, 0, 1'b0, "t5r");

    // Randomized traffic over a small pool of lines
    for (int i = 0; i < 8; i++) pool[i] = $urandom_range(0, DEP - 1);
    prev_keep = 1'b0;
    for (int i = 0; i < 40; i++) begin
      int idx;
      bit wr;
      bit keep;
      int drop;
      logic [31:0] a;
      idx = pool[$urandom_range(0, 7)];
      wr = ($urandom_range(0, 1) == 0) || !model.exists(idx);
      a = 32'(idx * 32 + $urandom_range(0, 31));
      keep = (i != 39) && ($urandom_range(0, 2) == 0);
      drop = 0;
      if (!prev_keep && $urandom_range(0, 3) == 0) drop = $urandom_range(1, LAT - 1);
      req(wr, a, rnd_line(), prev_keep ? LAT + 1 : LAT, drop, keep, wr ? "rw" : "rr");
      prev_keep = keep;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
